// File: rtl/uart_msg_pkg.sv
// Purpose: byte codes and FSM state encoding for the UART game-event scheduler and comparator.
// Latency: none (constants and a pure selection function).
// Backpressure: n/a.
package uart_msg_pkg;

  typedef logic [7:0] msg_t;

  localparam msg_t MSG_LOSE  = 8'h4C;  // 'L'
  localparam msg_t MSG_HIT   = 8'h48;  // 'H'
  localparam msg_t MSG_READY = 8'h52;  // 'R'

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_DONE = 2'd1;
  localparam logic [1:0] GAP       = 2'd2;

  // Fixed priority: game over beats hit beats ready.
  function automatic msg_t msg_sel(input logic over, input logic hit);
    if (over) return MSG_LOSE;
    else if (hit) return MSG_HIT;
    else return MSG_READY;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Purpose: byte write / done handshake between the scheduler and the UART TX core.
// Latency: none (wires only).
// Backpressure: the TX core stalls the scheduler simply by withholding tx_done.
interface uart_tx_scheduler_if;
  import uart_msg_pkg::*;

  msg_t tx_data;
  logic tx_wr;
  logic tx_done;

  modport master (output tx_data, output tx_wr, input tx_done);
  modport slave  (input tx_data, input tx_wr, output tx_done);

endinterface

// File: rtl/uart_evt_latch.sv
// Purpose: rising-edge detect on one event level plus a saturating pending counter.
// Latency: edge in cycle k shows up in cnt during cycle k+1.
// Backpressure: requests accumulate up to 2**CNT_W-1; further edges only raise ovf.
module uart_evt_latch #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_lvl,
  input  logic             enable,
  input  logic             discard,
  input  logic             take,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic prev;
  logic rise;

  assign rise = in_lvl & ~prev;

  // Previous level; cleared on reset so a level already high at release counts as an edge.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= in_lvl;
  end

  // Pending count: an edge and a take in the same cycle cancel, so a fresh request is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (!enable || discard) begin
      cnt <= '0;
    end else if (rise && !take) begin
      if (cnt == CNT_MAX) ovf <= 1'b1;
      else                cnt <= cnt + CNT_W'(1);
    end else if (!rise && take) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Purpose: latch game events, pick one by fixed priority, send it as one byte to the UART TX core.
// Latency: event edge in cycle k -> pending in k+1 -> tx_wr in k+2 when idle.
// Backpressure: waits for tx_done (or a timeout), then a fixed idle gap before the next byte.
module uart_tx_scheduler
  import uart_msg_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int HIT_CNT_W      = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       multiplayer,
  input  logic                       player_ready,
  input  logic                       player_hit,
  input  logic                       game_over,
  uart_tx_scheduler_if.master        tx,
  output logic                       busy,
  output logic                       hit_overflow,
  output logic                       timeout_err
);

  localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

  logic [1:0]           state;
  logic [TW-1:0]        timer;
  logic                 over_lock;
  logic                 over_pend;
  logic                 ready_pend;
  logic [HIT_CNT_W-1:0] hit_cnt;
  logic                 hit_any;
  logic                 issue;
  logic                 take_over;
  logic                 take_hit;
  logic                 take_ready;
  // Single-bit flags just coalesce repeated edges; their overflow has no meaning.
  logic                 ready_ovf_unused;
  logic                 over_ovf_unused;

  assign hit_any    = (hit_cnt != '0);
  assign issue      = (state == IDLE) && multiplayer && (over_pend || hit_any || ready_pend);
  assign take_over  = issue && over_pend;
  assign take_hit   = issue && !over_pend && hit_any;
  assign take_ready = issue && !over_pend && !hit_any && ready_pend;
  assign busy       = (state != IDLE);

  uart_evt_latch #(.CNT_W(1)) u_over (
    .clk(clk), .rst(rst), .in_lvl(game_over), .enable(multiplayer), .discard(1'b0),
    .take(take_over), .cnt(over_pend), .ovf(over_ovf_unused)
  );

  uart_evt_latch #(.CNT_W(HIT_CNT_W)) u_hit (
    .clk(clk), .rst(rst), .in_lvl(player_hit), .enable(multiplayer), .discard(over_lock),
    .take(take_hit), .cnt(hit_cnt), .ovf(hit_overflow)
  );

  uart_evt_latch #(.CNT_W(1)) u_ready (
    .clk(clk), .rst(rst), .in_lvl(player_ready), .enable(multiplayer), .discard(over_lock),
    .take(take_ready), .cnt(ready_pend), .ovf(ready_ovf_unused)
  );

  // After LOSE goes out, hit/ready are muted until the game_over level falls.
  always_ff @(posedge clk) begin
    if (rst)             over_lock <= 1'b0;
    else if (take_over)  over_lock <= 1'b1;
    else if (!game_over) over_lock <= 1'b0;
  end

  // Issue / wait-for-done / inter-byte gap sequencer; tx_wr is a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      tx.tx_wr    <= 1'b0;
      tx.tx_data  <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      tx.tx_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            tx.tx_data <= msg_sel(over_pend, hit_any);
            tx.tx_wr   <= 1'b1;
            timer      <= '0;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx.tx_done) begin
            timer <= '0;
            state <= GAP;
          end else if (timer == TO_LAST) begin
            // Stalled transmitter: drop the byte rather than retry it.
            timeout_err <= 1'b1;
            timer       <= '0;
            state       <= GAP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose: directed check of latency, priority, lock-out, saturation, timeout, disable and reset.
// Latency: outputs sampled on the falling edge, inputs driven there too.
// Backpressure: tx_done is driven by hand to stall or release the scheduler.
module tb_uart_tx_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic multiplayer;
  logic player_ready;
  logic player_hit;
  logic game_over;
  logic busy;
  logic hit_overflow;
  logic timeout_err;

  int n_cmp = 0;
  int n_mis = 0;

  uart_tx_scheduler_if tx();

  uart_tx_scheduler #(
    .GAP_CYCLES(16), .TIMEOUT_CYCLES(100), .HIT_CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .multiplayer(multiplayer), .player_ready(player_ready),
    .player_hit(player_hit), .game_over(game_over), .tx(tx), .busy(busy),
    .hit_overflow(hit_overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic hit_pulse();
    player_hit = 1'b1;
    tick();
    player_hit = 1'b0;
    tick();
  endtask

  task automatic done_pulse();
    tx.tx_done = 1'b1;
    tick();
    tx.tx_done = 1'b0;
  endtask

  // Waits (bounded) for the next tx_wr; n is the number of falling edges waited.
  task automatic wait_wr(input string tag, output int n);
    n = 0;
    while (!tx.tx_wr && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, {31'd0, tx.tx_wr}, 32'd1);
  endtask

  task automatic serve(input string tag, input logic [7:0] exp, input int delay);
    int n;
    wait_wr(tag, n);
    chk(tag, {24'd0, tx.tx_data}, {24'd0, exp});
    repeat (delay) tick();
    done_pulse();
  endtask

  task automatic count_wr(input int len, output int c);
    c = 0;
    repeat (len) begin
      tick();
      if (tx.tx_wr) c++;
    end
  endtask

  task automatic gap_len(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; multiplayer = 1'b1; player_ready = 1'b0; player_hit = 1'b0;
    game_over = 1'b0; tx.tx_done = 1'b0;

    // Reset state
    repeat (5) tick();
    chk("rst_wr", {31'd0, tx.tx_wr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {24'd0, tx.tx_data}, 32'd0);
    chk("rst_ovf", {31'd0, hit_overflow}, 32'd0);
    chk("rst_to", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    tick();
    tick();

    // 1: READY latency and inter-byte gap
    player_ready = 1'b1;
    tick();
    chk("t1_lat1", {31'd0, tx.tx_wr}, 32'd0);
    tick();
    chk("t1_wr", {31'd0, tx.tx_wr}, 32'd1);
    chk("t1_data", {24'd0, tx.tx_data}, 32'h52);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_single", {31'd0, tx.tx_wr}, 32'd0);
    repeat (49) tick();
    done_pulse();
    gap_len(n);
    chk("t1_gap", n, 32'd16);
    player_ready = 1'b0;

    // 2: simultaneous edges, LOSE locks out hit/ready
    tick();
    player_hit = 1'b1; game_over = 1'b1; player_ready = 1'b1;
    serve("t2_lose", 8'h4C, 5);
    count_wr(60, n);
    chk("t2_locked", n, 32'd0);
    game_over = 1'b0; player_hit = 1'b0; player_ready = 1'b0;
    repeat (3) tick();
    player_ready = 1'b1;
    serve("t2_ready", 8'h52, 5);
    count_wr(30, n);
    chk("t2_quiet", n, 32'd0);

    // 3: hit counter saturation while stalled
    player_ready = 1'b0;
    tick();
    player_ready = 1'b1;
    wait_wr("t3_r", n);
    chk("t3_r_data", {24'd0, tx.tx_data}, 32'h52);
    repeat (7) hit_pulse();
    chk("t3_ovf_7", {31'd0, hit_overflow}, 32'd0);
    repeat (2) hit_pulse();
    chk("t3_ovf_9", {31'd0, hit_overflow}, 32'd1);
    done_pulse();
    for (int i = 0; i < 7; i++) serve("t3_h", 8'h48, 3);
    count_wr(60, n);
    chk("t3_extra", n, 32'd0);

    // 4: timeout with a byte queued behind it
    hit_pulse();
    wait_wr("t4_h", n);
    chk("t4_h_data", {24'd0, tx.tx_data}, 32'h48);
    player_ready = 1'b0;
    tick();
    player_ready = 1'b1;
    repeat (98) tick();
    chk("t4_to_99", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("t4_to_100", {31'd0, timeout_err}, 32'd1);
    wait_wr("t4_next", n);
    chk("t4_next_lat", n, 32'd17);
    chk("t4_next_data", {24'd0, tx.tx_data}, 32'h52);
    done_pulse();
    gap_len(n);

    // 5: multiplayer low ignores edges; in-flight byte still completes
    multiplayer = 1'b0;
    player_ready = 1'b0;
    tick();
    player_ready = 1'b1;
    tick();
    hit_pulse();
    player_ready = 1'b0;
    tick();
    player_ready = 1'b1;
    count_wr(20, n);
    chk("t5_disabled", n, 32'd0);
    multiplayer = 1'b1;
    count_wr(30, n);
    chk("t5_no_pend", n, 32'd0);
    player_ready = 1'b0;
    tick();
    player_ready = 1'b1;
    wait_wr("t5_r", n);
    chk("t5_r_data", {24'd0, tx.tx_data}, 32'h52);
    hit_pulse();
    multiplayer = 1'b0;
    repeat (5) tick();
    done_pulse();
    gap_len(n);
    chk("t5_gap", n, 32'd16);
    count_wr(40, n);
    chk("t5_none", n, 32'd0);

    // 6: reset during GAP with hits pending
    multiplayer = 1'b1;
    hit_pulse();
    wait_wr("t6_h", n);
    chk("t6_h_data", {24'd0, tx.tx_data}, 32'h48);
    repeat (3) hit_pulse();
    done_pulse();
    repeat (3) tick();
    chk("t6_in_gap", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    player_ready = 1'b0;
    tick();
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_data", {24'd0, tx.tx_data}, 32'd0);
    chk("t6_to", {31'd0, timeout_err}, 32'd0);
    chk("t6_ovf", {31'd0, hit_overflow}, 32'd0);
    rst = 1'b0;
    count_wr(40, n);
    chk("t6_no_wr", n, 32'd0);
    chk("t6_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
